// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, write-back select encodings, default widths
// and the EX-stage control bundle.
package core_pkg;

    localparam int unsigned XLEN_D = 32;
    localparam int unsigned RA_W_D = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] FROM_ALU = 2'b00;
    localparam logic [1:0] FROM_MEM = 2'b01;
    localparam logic [1:0] FROM_PC4 = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       alusrc;
        logic [4:0] aluop;
        logic [2:0] npcop;
        logic [1:0] wdsel;
        logic [2:0] dmtype;
        logic       branch;
    } ex_ctrl_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: decoded ID-stage fields, pipeline controls and the registered EX view.
interface id_ex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
);
    logic            hold_i;
    logic            flush_i;
    logic            id_valid_i;
    logic [6:0]      id_opcode_i;
    logic [2:0]      id_funct3_i;
    logic [RA_W-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic [XLEN-1:0] id_pc_i, id_rd1_i, id_rd2_i, id_imm_i;
    logic            id_regwrite_i, id_memwrite_i, id_alusrc_i;
    logic [4:0]      id_aluop_i;
    logic [2:0]      id_npcop_i;
    logic [1:0]      id_wdsel_i;
    logic [2:0]      id_dmtype_i;

    logic            stall_o;
    logic            ex_valid_o;
    logic [2:0]      ex_funct3_o;
    logic [RA_W-1:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [XLEN-1:0] ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
    logic            ex_regwrite_o, ex_memwrite_o, ex_alusrc_o;
    logic [4:0]      ex_aluop_o;
    logic [2:0]      ex_npcop_o;
    logic [1:0]      ex_wdsel_o;
    logic [2:0]      ex_dmtype_o;
    logic            ex_branch_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    modport master (
        output hold_i, flush_i, id_valid_i, id_opcode_i, id_funct3_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_pc_i, id_rd1_i, id_rd2_i, id_imm_i,
               id_regwrite_i, id_memwrite_i, id_alusrc_i, id_aluop_i,
               id_npcop_i, id_wdsel_i, id_dmtype_i,
        input  stall_o, ex_valid_o, ex_funct3_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
               ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_regwrite_o, ex_memwrite_o,
               ex_alusrc_o, ex_aluop_o, ex_npcop_o, ex_wdsel_o, ex_dmtype_o,
               ex_branch_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i, id_opcode_i, id_funct3_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_pc_i, id_rd1_i, id_rd2_i, id_imm_i,
               id_regwrite_i, id_memwrite_i, id_alusrc_i, id_aluop_i,
               id_npcop_i, id_wdsel_i, id_dmtype_i,
        output stall_o, ex_valid_o, ex_funct3_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
               ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_regwrite_o, ex_memwrite_o,
               ex_alusrc_o, ex_aluop_o, ex_npcop_o, ex_wdsel_o, ex_dmtype_o,
               ex_branch_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_hazard_lu.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID instruction.
module hazard_lu
    import core_pkg::*;
#(
    parameter int unsigned RA_W = RA_W_D
) (
    input  logic [6:0]      opcode_i,
    input  logic [RA_W-1:0] rs1_i,
    input  logic [RA_W-1:0] rs2_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic [1:0]      ex_wdsel_i,
    input  logic            ex_regwrite_i,
    input  logic            ex_valid_i,
    input  logic            id_valid_i,
    output logic            lu_c
);
    logic ex_is_load;
    logic rs_match;

    // x0 is never a real destination, so it cannot create a dependence
    assign ex_is_load = ex_valid_i & ex_regwrite_i & (ex_wdsel_i == FROM_MEM) & (|ex_rd_i);
    assign rs_match   = (uses_rs1(opcode_i) & (rs1_i == ex_rd_i))
                      | (uses_rs2(opcode_i) & (rs2_i == ex_rd_i));
    assign lu_c       = ex_is_load & id_valid_i & rs_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-redirect flush,
// global hold and stall/flush event counters.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_D,
    parameter int unsigned RA_W  = RA_W_D,
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    id_ex_stage_if.slave bus
);
    logic             valid_q, valid_d;
    ex_ctrl_t         ctrl_q, ctrl_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [RA_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]  pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu;

    hazard_lu #(.RA_W(RA_W)) u_hazard_lu (
        .opcode_i      (bus.id_opcode_i),
        .rs1_i         (bus.id_rs1_i),
        .rs2_i         (bus.id_rs2_i),
        .ex_rd_i       (rd_q),
        .ex_wdsel_i    (ctrl_q.wdsel),
        .ex_regwrite_i (ctrl_q.regwrite),
        .ex_valid_i    (valid_q),
        .id_valid_i    (bus.id_valid_i),
        .lu_c          (lu)
    );

    assign bus.stall_o = lu & ~bus.flush_i & ~bus.hold_i;

    // Priority: hold > flush > load-use bubble > capture
    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        funct3_d    = funct3_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        imm_d       = imm_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.hold_i) begin
            if (bus.flush_i || lu) begin
                valid_d  = 1'b0;
                ctrl_d   = '0;
                funct3_d = '0;
                rs1_d    = '0;
                rs2_d    = '0;
                rd_d     = '0;
                pc_d     = '0;
                rd1_d    = '0;
                rd2_d    = '0;
                imm_d    = '0;
                if (bus.flush_i) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                else             stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                valid_d  = bus.id_valid_i;
                ctrl_d   = '{regwrite: bus.id_regwrite_i, memwrite: bus.id_memwrite_i,
                             alusrc:   bus.id_alusrc_i,   aluop:    bus.id_aluop_i,
                             npcop:    bus.id_npcop_i,    wdsel:    bus.id_wdsel_i,
                             dmtype:   bus.id_dmtype_i,
                             branch:   (bus.id_opcode_i == OP_BRANCH)};
                funct3_d = bus.id_funct3_i;
                rs1_d    = bus.id_rs1_i;
                rs2_d    = bus.id_rs2_i;
                rd_d     = bus.id_rd_i;
                pc_d     = bus.id_pc_i;
                rd1_d    = bus.id_rd1_i;
                rd2_d    = bus.id_rd2_i;
                imm_d    = bus.id_imm_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            funct3_q    <= funct3_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            pc_q        <= pc_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ex_valid_o    = valid_q;
    assign bus.ex_regwrite_o = ctrl_q.regwrite;
    assign bus.ex_memwrite_o = ctrl_q.memwrite;
    assign bus.ex_alusrc_o   = ctrl_q.alusrc;
    assign bus.ex_aluop_o    = ctrl_q.aluop;
    assign bus.ex_npcop_o    = ctrl_q.npcop;
    assign bus.ex_wdsel_o    = ctrl_q.wdsel;
    assign bus.ex_dmtype_o   = ctrl_q.dmtype;
    assign bus.ex_branch_o   = ctrl_q.branch;
    assign bus.ex_funct3_o   = funct3_q;
    assign bus.ex_rs1_o      = rs1_q;
    assign bus.ex_rs2_o      = rs2_q;
    assign bus.ex_rd_o       = rd_q;
    assign bus.ex_pc_o       = pc_q;
    assign bus.ex_rd1_o      = rd1_q;
    assign bus.ex_rd2_o      = rd2_q;
    assign bus.ex_imm_o      = imm_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against an
// instruction-level reference model of the ID/EX register.
module tb_id_ex_stage;
    import core_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what EX should hold, as plain fields
    logic            m_valid, m_regwrite, m_memwrite, m_alusrc, m_branch;
    logic [4:0]      m_aluop;
    logic [2:0]      m_npcop, m_dmtype, m_funct3;
    logic [1:0]      m_wdsel;
    logic [RA_W-1:0] m_rs1, m_rs2, m_rd;
    logic [XLEN-1:0] m_pc, m_rd1, m_rd2, m_imm;
    int              m_sc, m_fc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_regwrite = 0; m_memwrite = 0; m_alusrc = 0; m_branch = 0;
        m_aluop = 0; m_npcop = 0; m_dmtype = 0; m_funct3 = 0; m_wdsel = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
    endtask

    // A load producing rd in EX blocks any ID instruction that reads rd
    function automatic bit model_lu();
        bit reads1, reads2, ex_load;
        reads1  = !(bus.id_opcode_i inside {7'b0110111, 7'b0010111, 7'b1101111});
        reads2  = bus.id_opcode_i inside {7'b0110011, 7'b0100011, 7'b1100011};
        ex_load = m_valid && m_regwrite && m_wdsel == 2'b01 && m_rd != 0;
        return ex_load && bus.id_valid_i &&
               ((reads1 && bus.id_rs1_i == m_rd) || (reads2 && bus.id_rs2_i == m_rd));
    endfunction

    function automatic bit model_stall();
        return model_lu() && !bus.flush_i && !bus.hold_i;
    endfunction

    task automatic model_edge();
        bit lu;
        lu = model_lu();
        if (bus.hold_i) return;
        if (bus.flush_i) begin
            model_clear();
            m_fc = (m_fc + 1) % 16;
        end else if (lu) begin
            model_clear();
            m_sc = (m_sc + 1) % 16;
        end else begin
            m_valid = bus.id_valid_i;   m_regwrite = bus.id_regwrite_i;
            m_memwrite = bus.id_memwrite_i; m_alusrc = bus.id_alusrc_i;
            m_aluop = bus.id_aluop_i;   m_npcop = bus.id_npcop_i;
            m_wdsel = bus.id_wdsel_i;   m_dmtype = bus.id_dmtype_i;
            m_branch = (bus.id_opcode_i == 7'b1100011);
            m_funct3 = bus.id_funct3_i; m_rs1 = bus.id_rs1_i; m_rs2 = bus.id_rs2_i;
            m_rd = bus.id_rd_i; m_pc = bus.id_pc_i; m_rd1 = bus.id_rd1_i;
            m_rd2 = bus.id_rd2_i; m_imm = bus.id_imm_i;
        end
    endtask

    task automatic compare_all();
        chk("ex_valid", 64'(bus.ex_valid_o), 64'(m_valid));
        chk("ex_ctrl",
            64'({bus.ex_regwrite_o, bus.ex_memwrite_o, bus.ex_alusrc_o, bus.ex_aluop_o,
                 bus.ex_npcop_o, bus.ex_wdsel_o, bus.ex_dmtype_o, bus.ex_branch_o}),
            64'({m_regwrite, m_memwrite, m_alusrc, m_aluop, m_npcop, m_wdsel, m_dmtype,
                 m_branch}));
        chk("ex_regs", 64'({bus.ex_funct3_o, bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o}),
            64'({m_funct3, m_rs1, m_rs2, m_rd}));
        chk("ex_pc", 64'(bus.ex_pc_o), 64'(m_pc));
        chk("ex_rd1_rd2", {bus.ex_rd1_o, bus.ex_rd2_o}, {m_rd1, m_rd2});
        chk("ex_imm", 64'(bus.ex_imm_o), 64'(m_imm));
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_sc));
        chk("flush_cnt", 64'(bus.flush_cnt_o), 64'(m_fc));
    endtask

    // Inputs are set just after a rising edge; stall is checked mid-cycle
    task automatic cycle();
        @(negedge clk);
        chk("stall_o", 64'(bus.stall_o), 64'(model_stall()));
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input int rs1, input int rs2,
                         input int rd, input logic rw, input logic [1:0] ws);
        bus.id_valid_i    = v;
        bus.id_opcode_i   = op;
        bus.id_rs1_i      = RA_W'(rs1);
        bus.id_rs2_i      = RA_W'(rs2);
        bus.id_rd_i       = RA_W'(rd);
        bus.id_regwrite_i = rw;
        bus.id_wdsel_i    = ws;
        bus.id_funct3_i   = 3'($urandom);
        bus.id_pc_i       = $urandom;
        bus.id_rd1_i      = $urandom;
        bus.id_rd2_i      = $urandom;
        bus.id_imm_i      = $urandom;
        bus.id_memwrite_i = 1'($urandom);
        bus.id_alusrc_i   = 1'($urandom);
        bus.id_aluop_i    = 5'($urandom);
        bus.id_npcop_i    = 3'($urandom);
        bus.id_dmtype_i   = 3'($urandom);
    endtask

    task automatic idle_inputs();
        bus.hold_i  = 0;
        bus.flush_i = 0;
        drive(0, 7'b0, 0, 0, 0, 0, 2'b00);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic async_reset();
        rstn = 0;
        #1;
        model_clear();
        m_sc = 0;
        m_fc = 0;
        compare_all();
        idle_inputs();
        chk("stall_in_reset", 64'(bus.stall_o), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1;
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        idle_inputs();
        m_sc = 0;
        m_fc = 0;
        #2;
        async_reset();
        cycle();

        // Load-use: lw x5 then add x6,x5,x7
        drive(1, OP_LOAD, 1, 0, 5, 1, FROM_MEM); cycle();
        drive(1, OP_R, 5, 7, 6, 1, FROM_ALU);    cycle();
        chk("lu_bubble_valid", 64'(bus.ex_valid_o), 64'(0));
        chk("lu_stall_cnt", 64'(bus.stall_cnt_o), 64'(1));
        cycle();
        chk("lu_add_rs1", 64'(bus.ex_rs1_o), 64'(5));

        // No false hazards: x0 destination, lui, then store with only rs1 matching
        drive(1, OP_LOAD, 1, 0, 0, 1, FROM_MEM); cycle();
        drive(1, OP_R, 0, 0, 6, 1, FROM_ALU);    cycle();
        drive(1, OP_LOAD, 1, 0, 5, 1, FROM_MEM); cycle();
        drive(1, OP_LUI, 5, 5, 5, 1, FROM_ALU);  cycle();
        drive(1, OP_LOAD, 1, 0, 5, 1, FROM_MEM); cycle();
        drive(1, OP_STORE, 5, 9, 0, 0, FROM_ALU); cycle();
        chk("store_rs1_stalled", 64'(bus.ex_valid_o), 64'(0));
        cycle();

        // Flush wins over load-use
        async_reset();
        drive(1, OP_LOAD, 1, 0, 5, 1, FROM_MEM); cycle();
        drive(1, OP_R, 5, 7, 6, 1, FROM_ALU);
        bus.flush_i = 1;
        cycle();
        chk("flush_cnt_once", 64'(bus.flush_cnt_o), 64'(1));
        chk("flush_no_stall_cnt", 64'(bus.stall_cnt_o), 64'(0));
        bus.flush_i = 0;

        // Hold freezes EX while ID changes
        drive(1, OP_IMM, 2, 0, 3, 1, FROM_ALU); cycle();
        bus.hold_i = 1;
        drive(1, OP_IMM, 4, 0, 8, 1, FROM_ALU);
        bus.id_pc_i = 32'h100;
        repeat (3) cycle();
        bus.hold_i = 0;
        cycle();
        chk("hold_release_pc", 64'(bus.ex_pc_o), 64'h100);

        // 17 flushes wrap a 4-bit counter to 1, then reset mid-sequence
        async_reset();
        bus.flush_i = 1;
        repeat (17) cycle();
        chk("flush_wrap", 64'(bus.flush_cnt_o), 64'(1));
        repeat (3) cycle();
        async_reset();

        // Randomized traffic with a small register pool for frequent hazards
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) != 0), ops[$urandom_range(0, 8)],
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom), 2'($urandom));
            bus.hold_i  = ($urandom_range(0, 9) == 0);
            bus.flush_i = ($urandom_range(0, 6) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
